// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the fetch/data SRAM arbiter.
//   state_t : FSM encodings IDLE/BUSY/DONE
//   owner_t : access owner, OWN_IF (fetch) or OWN_D (data)
//   CNT_W   : latency counter width
//   pick()  : round-robin choice between the two request lines
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

   localparam int CNT_W = 4;

   // With both requests pending the port that did not win last time wins now.
   function automatic owner_t pick(input logic if_req, input logic d_req, input owner_t last);
      return (if_req && d_req) ? ((last == OWN_IF) ? OWN_D : OWN_IF) : (d_req ? OWN_D : OWN_IF);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_cnt.sv
// mem_port_arbiter_lat_cnt: 4-bit load/clear latency counter with terminal count at LAT.
//   clk, rst_n : clock, asynchronous active-low reset
//   ld         : load 1 (first SRAM cycle of an access)
//   inc        : advance by one
//   clr        : return to 0 (wins over ld and inc)
//   tc         : counter equals LAT
module mem_port_arbiter_lat_cnt
   import mem_port_arbiter_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ld,
   input  logic inc,
   input  logic clr,
   output logic tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (ld) cnt <= CNT_W'(1);
      else if (inc) cnt <= cnt + 1'b1;
   end

   assign tc = cnt == CNT_W'(LAT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle single-port SRAM between fetch and data ports.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   if_req/if_addr                  : fetch request (read only)
//   if_done/if_rdata/if_stall       : fetch completion pulse, held read data, stall
//   d_req/d_we/d_addr/d_wdata       : load/store request
//   d_done/d_rdata/d_stall          : data completion pulse, held load data, stall
//   sram_cs/oe/we/addr/din, sram_dout : SRAM interface, address/data registered at grant
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_stall,
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
);

   state_t state, nxt;
   owner_t owner, last, gnt;
   logic   we_r, tc, any_req, start;

   assign any_req = if_req | d_req;
   assign gnt     = pick(if_req, d_req, last);
   assign start   = (state == IDLE) && any_req;

   // BUSY spans counts 1..LAT; the counter is loaded on grant so the first BUSY cycle reads 1.
   mem_port_arbiter_lat_cnt #(.LAT(LAT)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (start),
      .inc   ((state == BUSY) && !tc),
      .clr   (state == DONE),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= nxt;
   end

   always_comb begin
      nxt = (state == IDLE) ? (any_req ? BUSY : IDLE) :
            (state == BUSY) ? (tc ? DONE : BUSY) : IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner     <= OWN_IF;
         last      <= OWN_D;
         we_r      <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if (start) begin
            owner     <= gnt;
            last      <= gnt;
            we_r      <= (gnt == OWN_D) && d_we;
            sram_addr <= (gnt == OWN_D) ? d_addr : if_addr;
            if (gnt == OWN_D) sram_din <= d_wdata;
         end
         // Stores leave both read-data registers untouched.
         if ((state == BUSY) && tc && !we_r) begin
            if (owner == OWN_IF) if_rdata <= sram_dout;
            else d_rdata <= sram_dout;
         end
      end
   end

   always_comb begin
      sram_cs  = state == BUSY;
      sram_oe  = sram_cs && !we_r;
      sram_we  = sram_cs && we_r;
      if_done  = (state == DONE) && (owner == OWN_IF);
      d_done   = (state == DONE) && (owner == OWN_D);
      if_stall = if_req && !if_done;
      d_stall  = d_req && !d_done;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter (LAT=2) plus LAT=1/15 latency instances.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic        if_done, if_stall, d_done, d_stall, sram_cs, sram_oe, sram_we;
   logic [31:0] if_rdata, d_rdata, sram_addr, sram_din, sram_dout;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
      .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   // SRAM environment: read data becomes valid on the LAT-th cycle of a steady read.
   logic [31:0] img [0:255];
   logic [31:0] sram [0:255];
   int          oe_run = 0;

   always @(posedge clk) begin
      if (sram_cs && sram_we) sram[sram_addr[9:2]] <= sram_din;
      oe_run <= (sram_cs && sram_oe) ? oe_run + 1 : 0;
   end

   assign sram_dout = (sram_cs && sram_oe && oe_run >= LAT - 1) ? sram[sram_addr[9:2]] : 32'hBAD0BAD0;

   // Two extra instances with LAT=1 and LAT=15, fetch port only.
   logic        x_req [2];
   logic [31:0] x_if_addr [2];
   logic        x_if_done [2], x_if_stall [2], x_d_done [2], x_d_stall [2];
   logic        x_cs [2], x_oe [2], x_we [2];
   logic [31:0] x_if_rdata [2], x_d_rdata [2], x_addr [2], x_din [2], x_dout [2];

   for (genvar g = 0; g < 2; g++) begin : gl
      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(g == 0 ? 1 : 15)) u (
         .clk(clk), .rst_n(rst_n),
         .if_req(x_req[g]), .if_addr(x_if_addr[g]), .if_done(x_if_done[g]),
         .if_rdata(x_if_rdata[g]), .if_stall(x_if_stall[g]),
         .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
         .d_done(x_d_done[g]), .d_rdata(x_d_rdata[g]), .d_stall(x_d_stall[g]),
         .sram_cs(x_cs[g]), .sram_oe(x_oe[g]), .sram_we(x_we[g]),
         .sram_addr(x_addr[g]), .sram_din(x_din[g]), .sram_dout(x_dout[g])
      );
      assign x_dout[g] = (x_cs[g] && x_oe[g]) ? ~x_addr[g] : 32'h0;
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   task automatic fail_rec(input string nm);
      n_chk++;
      $display("FAIL %s actual=absent required=present", nm);
   endtask

   // Reference model: fetch region is read-only image, data region tracked in ref_d.
   logic [31:0] ref_d [0:255];
   logic [31:0] ref_rd = '0;
   logic [31:0] if_q [$];
   logic [31:0] d_q [$];
   logic        must_valid = 1'b0, must_own = 1'b0;
   logic [5:0]  ord = '0;

   // Scoreboard monitor: data on every done, stall every cycle, and the
   // rule that a port pending across the other's done is served next.
   always @(negedge clk) begin
      if (!rst_n) must_valid = 1'b0;
      else begin
         chk("if_stall", 32'(if_stall), 32'(if_req & ~if_done));
         chk("d_stall", 32'(d_stall), 32'(d_req & ~d_done));
         if (if_done) begin
            if (if_q.size() == 0) fail_rec("if_expected_done");
            else chk("if_rdata", if_rdata, if_q.pop_front());
            if (must_valid) chk("grant_order_if", 32'(0), 32'(must_own));
            must_valid = d_req;
            must_own = 1'b1;
            ord = {ord[4:0], 1'b0};
         end
         if (d_done) begin
            if (d_q.size() == 0) fail_rec("d_expected_done");
            else chk("d_rdata", d_rdata, d_q.pop_front());
            if (must_valid) chk("grant_order_d", 32'(1), 32'(must_own));
            must_valid = if_req;
            must_own = 1'b0;
            ord = {ord[4:0], 1'b1};
         end
      end
   end

   task automatic fetch(input logic [31:0] a, output int lat);
      if_q.push_back(img[a[9:2]]);
      if_addr = a;
      if_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!if_done && lat < 100);
      if (!if_done) fail_rec("if_done_timeout");
      @(posedge clk);
      #1 if_req = 1'b0;
   endtask

   task automatic daccess(input logic we, input logic [31:0] a, input logic [31:0] wd, output int lat);
      if (we) ref_d[a[9:2]] = wd;
      else ref_rd = ref_d[a[9:2]];
      d_q.push_back(ref_rd);
      d_we = we;
      d_addr = a;
      d_wdata = wd;
      d_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!d_done && lat < 100);
      if (!d_done) fail_rec("d_done_timeout");
      @(posedge clk);
      #1 d_req = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      ref_rd = '0;
      if_q.delete();
      d_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [31:0] if_rand();
      return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   function automatic logic [31:0] d_rand();
      return ($urandom & 32'hFFFF_FC00) | 32'h100 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   int l1, l2, wc, nd, lt, cs_n;

   initial begin
      for (int i = 0; i < 256; i++) begin
         img[i] = $urandom;
         if (i == 16) img[i] = 32'h8C22_0004;
         sram[i] = img[i];
         ref_d[i] = img[i];
      end
      for (int k = 0; k < 2; k++) begin
         x_req[k] = 1'b0;
         x_if_addr[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", 32'({sram_cs, sram_oe, sram_we, if_done, d_done}), 32'h0);
      chk("rst_addr", sram_addr, 32'h0);
      chk("rst_din", sram_din, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      rst_n = 1'b1;

      // Reset in the middle of an access aborts it without a done.
      @(posedge clk);
      #1 if_addr = 32'h44;
      if_req = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("pre_abort_cs", 32'(sram_cs), 32'h1);
      rst_n = 1'b0;
      #1 chk("abort_ctrl", 32'({sram_cs, sram_oe, sram_we, if_done, d_done}), 32'h0);
      chk("abort_addr", sram_addr, 32'h0);
      if_req = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      nd = 0;
      repeat (10) begin
         @(negedge clk);
         nd += int'(if_done | d_done);
      end
      chk("no_stale_done", nd, 0);

      // Single fetch of 0x40.
      @(posedge clk);
      #1;
      fork
         fetch(32'h40, l1);
         repeat (LAT + 2) begin
            @(negedge clk);
            if (sram_cs) begin
               chk("fetch_sram_addr", sram_addr, 32'h40);
               chk("fetch_sram_oe", 32'(sram_oe), 32'h1);
            end
         end
      join
      chk("fetch_latency", l1, LAT + 2);

      // Store, then load it back.
      wc = 0;
      fork
         daccess(1'b1, 32'h100, 32'hDEAD_BEEF, l2);
         repeat (LAT + 2) begin
            @(negedge clk);
            if (sram_we) begin
               wc++;
               chk("store_din", sram_din, 32'hDEAD_BEEF);
               chk("store_addr", sram_addr, 32'h100);
            end
         end
      join
      chk("store_we_cycles", wc, LAT);
      chk("store_latency", l2, LAT + 2);
      daccess(1'b0, 32'h100, 32'h0, l2);

      // Simultaneous requests right after reset: fetch first.
      do_reset();
      fork
         fetch(32'h80, l1);
         daccess(1'b0, 32'h104, 32'h0, l2);
      join
      chk("both_if_latency", l1, LAT + 2);
      chk("both_d_latency", l2, 2 * (LAT + 2));

      // Both held continuously for six accesses.
      ord = '0;
      fork
         for (int i = 0; i < 3; i++) fetch(if_rand(), l1);
         for (int i = 0; i < 3; i++) daccess(1'($urandom), d_rand(), $urandom, l2);
      join
      chk("alternation", 32'(ord), 32'(6'b010101));

      // Random traffic on both ports.
      fork
         for (int i = 0; i < 30; i++) begin
            int la;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
            fetch(if_rand(), la);
            if (la > 2 * (LAT + 2)) chk("if_wait_bound", la, 2 * (LAT + 2));
         end
         for (int i = 0; i < 30; i++) begin
            int lb;
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk);
               #1;
            end
            daccess(1'($urandom), d_rand(), $urandom, lb);
            if (lb > 2 * (LAT + 2)) chk("d_wait_bound", lb, 2 * (LAT + 2));
         end
      join
      chk("if_q_drained", if_q.size(), 0);
      chk("d_q_drained", d_q.size(), 0);

      // Latency sweep on the LAT=1 and LAT=15 instances.
      for (int k = 0; k < 2; k++) begin
         lt = (k == 0) ? 1 : 15;
         @(posedge clk);
         #1 x_if_addr[k] = $urandom;
         x_req[k] = 1'b1;
         l1 = 0;
         cs_n = 0;
         do begin
            @(negedge clk);
            l1++;
            cs_n += int'(x_cs[k]);
         end while (!x_if_done[k] && l1 < 100);
         chk("sweep_latency", l1, lt + 2);
         chk("sweep_cs_cycles", cs_n, lt);
         chk("sweep_rdata", x_if_rdata[k], ~x_if_addr[k]);
         @(posedge clk);
         #1 x_req[k] = 1'b0;
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
